// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
//   state_t    : response-phase encoding (which port's response is due this cycle)
//   PORT_CORE  : index of the multi-cycle core port
//   PORT_DMA   : index of the program loader / DMA port
//   resp_state : maps a granted port index to its response state
package mem_arb_pkg;

  localparam int unsigned AW_DEF = 10;
  localparam int unsigned DW_DEF = 32;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP0 = 2'd1,
    RESP1 = 2'd2
  } state_t;

  // Response state owed to the port that wins this cycle.
  function automatic state_t resp_state(input logic port);
    return (port == PORT_DMA) ? RESP1 : RESP0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   req0, req1 : request inputs
//   last_gnt   : port granted most recently (held by the caller)
//   gnt0, gnt1 : one-hot grant (both 0 when nobody requests)
//   sel        : index of the winning port (0 when nobody requests)
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt0,
  output logic gnt1,
  output logic sel
);

  logic w_both;

  assign w_both = req0 & req1;

  // On a tie the port that did not win last time goes next; otherwise the lone requester wins.
  assign sel  = w_both ? ~last_gnt : (req1 ? PORT_DMA : PORT_CORE);
  assign gnt0 = req0 & (sel == PORT_CORE);
  assign gnt1 = req1 & (sel == PORT_DMA);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the core (port 0)
// and the loader/DMA (port 1), one access per cycle, round-robin on contention.
//   clk, reset          : clock and synchronous active-high reset
//   req/we/addr/wdata N : request from port N, held stable until gntN
//   gntN                : combinational, access of port N issued this cycle
//   rvalidN, rdataN     : response one cycle after grant (rdata 0 on writes)
//   mem_*               : memory interface, mem_rdata valid the cycle after mem_en
// Optional build macro MEM_ARB_PERF_CNT_EN adds saturating 32-bit counters
// gnt_cnt0, gnt_cnt1 and conflict_cnt.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
`ifdef MEM_ARB_PERF_CNT_EN
  output logic [31:0]   gnt_cnt0,
  output logic [31:0]   gnt_cnt1,
  output logic [31:0]   conflict_cnt,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t r_state;
  logic   r_last_gnt;
  logic   r_resp_we;

  logic   w_req0;
  logic   w_req1;
  logic   w_gnt0;
  logic   w_gnt1;
  logic   w_sel;
  logic   w_any;

  // Requests are masked during reset so nothing reaches the memory.
  assign w_req0 = req0 & ~reset;
  assign w_req1 = req1 & ~reset;

  rr_arb2 u_rr_arb2 (
    .req0     (w_req0),
    .req1     (w_req1),
    .last_gnt (r_last_gnt),
    .gnt0     (w_gnt0),
    .gnt1     (w_gnt1),
    .sel      (w_sel)
  );

  assign w_any = w_gnt0 | w_gnt1;
  assign gnt0  = w_gnt0;
  assign gnt1  = w_gnt1;

  // Memory mux: all fields forced to 0 when nothing is granted.
  assign mem_en    = w_any;
  assign mem_we    = w_any & ((w_sel == PORT_DMA) ? we1 : we0);
  assign mem_addr  = w_any ? ((w_sel == PORT_DMA) ? addr1 : addr0) : '0;
  assign mem_wdata = w_any ? ((w_sel == PORT_DMA) ? wdata1 : wdata0) : '0;

  // Response FSM: a grant in any state schedules that port's response next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_gnt <= PORT_DMA;
      r_resp_we  <= 1'b0;
    end else if (w_any) begin
      r_state    <= resp_state(w_sel);
      r_last_gnt <= w_sel;
      r_resp_we  <= mem_we;
    end else begin
      r_state    <= IDLE;
    end
  end

  // Reset also squashes a response already scheduled by the previous edge.
  assign rvalid0 = (r_state == RESP0) & ~reset;
  assign rvalid1 = (r_state == RESP1) & ~reset;
  assign rdata0  = (rvalid0 & ~r_resp_we) ? mem_rdata : '0;
  assign rdata1  = (rvalid1 & ~r_resp_we) ? mem_rdata : '0;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] r_gnt_cnt0;
  logic [31:0] r_gnt_cnt1;
  logic [31:0] r_conflict_cnt;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt_cnt0     <= 32'd0;
      r_gnt_cnt1     <= 32'd0;
      r_conflict_cnt <= 32'd0;
    end else begin
      if (w_gnt0 && (r_gnt_cnt0 != 32'hFFFF_FFFF))
        r_gnt_cnt0 <= r_gnt_cnt0 + 32'd1;
      if (w_gnt1 && (r_gnt_cnt1 != 32'hFFFF_FFFF))
        r_gnt_cnt1 <= r_gnt_cnt1 + 32'd1;
      if (w_req0 && w_req1 && (r_conflict_cnt != 32'hFFFF_FFFF))
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign gnt_cnt0     = r_gnt_cnt0;
  assign gnt_cnt1     = r_gnt_cnt1;
  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters: port 0 is the multi-cycle core (fetch, load and store), port 1 is the program loader/DMA.
- Arbitrates round-robin and issues at most one memory access per cycle.
- Returns read data and write acknowledgements to the winning requester exactly one cycle after grant.
- Sits between the core's adr_src-selected memory interface and the unified instruction/data RAM.

Parameters:
- AW, 10, word-address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  core requests an access; held with we0/addr0/wdata0 stable until gnt0.
- we0  in  1  1 = write, 0 = read.
- addr0  in  AW  core word address.
- wdata0  in  DW  core write data.
- gnt0  out  1  combinational; the access is issued to memory this cycle.
- rvalid0  out  1  response for port 0 this cycle (read data, or write acknowledge).
- rdata0  out  DW  read data; 0 when rvalid0=0.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same widths and rules for the loader/DMA port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset values: state=IDLE, last_gnt=1 (core wins the first tie), rvalid0=rvalid1=0, rdata0=rdata1=0.
- While reset is high: gnt0, gnt1, mem_en and mem_we are 0.
- Combinational outputs: gnt0, gnt1, mem_en, mem_we, mem_addr, mem_wdata.
- Registered: state, last_gnt.

Grant selection, every cycle and in any state:
- Only req0 → grant 0.
- Only req1 → grant 1.
- Both → grant the port != last_gnt.
- Neither → no grant; mem_en=0; mem_addr, mem_wdata and mem_we driven 0.

On a grant to port p:
- gnt_p=1 and mem_en=1.
- mem_we, mem_addr and mem_wdata are muxed from port p.
- last_gnt <= p.

State machine:
- States: IDLE, RESP0, RESP1. The state names which port's response is due this cycle.
- Next state = RESP_p if a grant to p was issued, else IDLE. The transition is taken from any state, so back-to-back accesses give full throughput.
- In RESP_p: rvalid_p=1; rdata_p=mem_rdata for a read, rdata_p=0 for a write. The op type is latched as resp_we at grant.
- Latency: grant at cycle T, response at T+1 without fail.

Boundary conditions:
- A requester dropping req before gnt is legal; nothing is issued.
- A requester may re-request in its own RESP cycle.
- Continuous contention alternates 0,1,0,1… so neither port starves.
- Reset mid-access: the pending response is discarded and no rvalid is produced after reset.
- The memory write still completes if the edge already occurred.
- The arbiter does not track addresses; write/read hazards to the same address across ports are resolved by grant order.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds three outputs, each 32 bits, reset to 0 and saturating at all-ones:
  - gnt_cnt0: increments on every gnt0.
  - gnt_cnt1: increments on every gnt1.
  - conflict_cnt: increments each cycle with req0&req1.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding: IDLE=2'd0, RESP0=2'd1, RESP1=2'd2.
  - port index constants PORT_CORE=0, PORT_DMA=1.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: req0, req1, last_gnt.
  - Outputs: gnt0, gnt1, sel.
  - Purely combinational. last_gnt is held in mem_arbiter.

Test Plan:
- Reset, then req0 read of addr 0x004 (mem returns 0x00500093) → gnt0 at T; rvalid0=1, rdata0=0x00500093 at T+1; rvalid1=0.
- req0 and req1 both asserted for 4 cycles from reset → grants 0,1,0,1; mem_addr alternates addr0/addr1; rvalid pulses follow one cycle later.
- req1 write addr 0x010, data 0xDEADBEEF, then req0 read of 0x010 → mem_we=1 at the first grant; rvalid1=1 with rdata1=0; the next read returns 0xDEADBEEF to port 0.
- Back-to-back core reads of 0x000, 0x001, 0x002 on consecutive cycles → gnt0 on 3 cycles; rvalid0 on the 3 following cycles with in-order data.
- Grant at T, reset asserted at T+1 → rvalid0=0 at T+1 and after; state=IDLE; the next tie grants port 0.
- With MEM_ARB_PERF_CNT_EN: 5 contended cycles → conflict_cnt=5, gnt_cnt0=3, gnt_cnt1=2.
